// File: rtl/peridot_pfc_arbiter_if.sv
// Avalon-MM slave port bundle for one master of the PERIDOT PFC arbiter.
// The master modport is the requesting side; the slave modport is the arbiter side.
interface peridot_pfc_arbiter_if;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/peridot_pfc_arbiter.sv
// Two-master round-robin arbiter for the PERIDOT PFC register bus.
// Define PERIDOT_PFC_BOOTINIT_EN to write INIT_PINFUNC/INIT_FUNCPIN into all banks after reset.
module peridot_pfc_arbiter #(
    parameter logic [127:0] INIT_PINFUNC = 128'h0,
    parameter logic [127:0] INIT_FUNCPIN = 128'h0
) (
    input  logic                        csi_clk,
    input  logic                        rsi_reset_n,
    peridot_pfc_arbiter_if.slave        avs_s0,
    peridot_pfc_arbiter_if.slave        avs_s1,
    output logic                        coe_pfc_clk,
    output logic                        coe_pfc_reset,
    output logic [3:0]                  coe_pfc_address,
    output logic                        coe_pfc_write,
    output logic [31:0]                 coe_pfc_writedata,
    input  logic [31:0]                 coe_pfc_readdata,
    output logic [2:0]                  o_dbg_state
);

`ifdef PERIDOT_PFC_BOOTINIT_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_ACK, ST_INIT} state_t;
    localparam state_t ST_RESET = ST_INIT;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_ACK} state_t;
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t      r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [3:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_wait0;
    logic        r_wait1;
    logic        r_pfc_write;

    logic        w_req0;
    logic        w_req1;
    logic        w_pick1;
    logic [3:0]  w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_write;

    assign w_req0 = avs_s0.read | avs_s0.write;
    assign w_req1 = avs_s1.read | avs_s1.write;
    // On a tie the master that was not served last wins (r_last_grant = 1 means master 1).
    assign w_pick1     = w_req1 & (~w_req0 | ~r_last_grant);
    assign w_sel_addr  = w_pick1 ? avs_s1.address   : avs_s0.address;
    assign w_sel_wdata = w_pick1 ? avs_s1.writedata : avs_s0.writedata;
    assign w_sel_write = w_pick1 ? avs_s1.write     : avs_s0.write;

`ifdef PERIDOT_PFC_BOOTINIT_EN
    logic [3:0]  r_init_cnt;
    logic [1:0]  w_init_bank;
    logic [3:0]  w_init_addr;
    logic [31:0] w_init_data;

    // Step k writes bank k/2; even steps hit pinfunc (4n+2), odd steps funcpin (4n+3).
    assign w_init_bank = r_init_cnt[2:1];
    assign w_init_addr = {r_init_cnt[2:1], 1'b1, r_init_cnt[0]};
    assign w_init_data = r_init_cnt[0] ? INIT_FUNCPIN[{w_init_bank, 5'd0} +: 32]
                                       : INIT_PINFUNC[{w_init_bank, 5'd0} +: 32];
`else
    logic w_unused_params;
    assign w_unused_params = ^{INIT_PINFUNC, INIT_FUNCPIN};
`endif

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            r_state      <= ST_RESET;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= 4'd0;
            r_wdata      <= 32'd0;
            r_rdata      <= 32'd0;
            r_wait0      <= 1'b1;
            r_wait1      <= 1'b1;
            r_pfc_write  <= 1'b0;
`ifdef PERIDOT_PFC_BOOTINIT_EN
            r_init_cnt   <= 4'd0;
`endif
        end else begin
            case (r_state)
`ifdef PERIDOT_PFC_BOOTINIT_EN
                ST_INIT: begin
                    if (r_init_cnt == 4'd8) begin
                        r_pfc_write <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_pfc_write <= 1'b1;
                        r_addr      <= w_init_addr;
                        r_wdata     <= w_init_data;
                        r_init_cnt  <= r_init_cnt + 4'd1;
                    end
                end
`endif
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant <= w_pick1;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        // A simultaneous read+write is served as a write.
                        if (w_sel_write) begin
                            r_pfc_write <= 1'b1;
                            r_state     <= ST_WR;
                        end else begin
                            r_state     <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    r_pfc_write <= 1'b0;
                    if (r_grant) r_wait1 <= 1'b0;
                    else         r_wait0 <= 1'b0;
                    r_state <= ST_ACK;
                end
                ST_RD: begin
                    r_rdata <= coe_pfc_readdata;
                    if (r_grant) r_wait1 <= 1'b0;
                    else         r_wait0 <= 1'b0;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_wait0      <= 1'b1;
                    r_wait1      <= 1'b1;
                    r_last_grant <= r_grant;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_RESET;
            endcase
        end
    end

    assign avs_s0.waitrequest = r_wait0;
    assign avs_s1.waitrequest = r_wait1;
    assign avs_s0.readdata    = r_rdata;
    assign avs_s1.readdata    = r_rdata;

    assign coe_pfc_clk       = csi_clk;
    assign coe_pfc_reset     = ~rsi_reset_n;
    assign coe_pfc_address   = r_addr;
    assign coe_pfc_write     = r_pfc_write;
    assign coe_pfc_writedata = r_wdata;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_peridot_pfc_arbiter.sv
// Self-checking bench for peridot_pfc_arbiter: PFC register-file model plus
// transaction-level expectations (latency, round-robin order, write stream).
module tb_peridot_pfc_arbiter;

    localparam logic [127:0] P_PINFUNC = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] P_FUNCPIN = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

    logic        csi_clk = 1'b0;
    logic        rsi_reset_n;
    logic        coe_pfc_clk;
    logic        coe_pfc_reset;
    logic [3:0]  coe_pfc_address;
    logic        coe_pfc_write;
    logic [31:0] coe_pfc_writedata;
    logic [31:0] coe_pfc_readdata;
    logic [2:0]  dbg_state;

    peridot_pfc_arbiter_if s0 ();
    peridot_pfc_arbiter_if s1 ();

    peridot_pfc_arbiter #(
        .INIT_PINFUNC (P_PINFUNC),
        .INIT_FUNCPIN (P_FUNCPIN)
    ) dut (
        .csi_clk           (csi_clk),
        .rsi_reset_n       (rsi_reset_n),
        .avs_s0            (s0),
        .avs_s1            (s1),
        .coe_pfc_clk       (coe_pfc_clk),
        .coe_pfc_reset     (coe_pfc_reset),
        .coe_pfc_address   (coe_pfc_address),
        .coe_pfc_write     (coe_pfc_write),
        .coe_pfc_writedata (coe_pfc_writedata),
        .coe_pfc_readdata  (coe_pfc_readdata),
        .o_dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 csi_clk = ~csi_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- PFC register file model ----------------
    logic [31:0] pfc_mem [16];
    logic        tb_load = 1'b0;
    logic [3:0]  tb_load_addr = 4'd0;
    logic [31:0] tb_load_data = 32'd0;

    always @(posedge csi_clk) begin
        if (coe_pfc_write)
            pfc_mem[coe_pfc_address] <= coe_pfc_writedata;
        else if (tb_load)
            pfc_mem[tb_load_addr] <= tb_load_data;
    end
    assign coe_pfc_readdata = pfc_mem[coe_pfc_address];

    // ---------------- scoreboard ----------------
    logic [31:0] model_mem [16];
    logic [35:0] exp_q[$];
    logic [35:0] obs_q[$];
    int errors = 0;
    int checks = 0;

    always @(negedge csi_clk)
        if (coe_pfc_write) obs_q.push_back({coe_pfc_address, coe_pfc_writedata});

    // ---------------- driver tasks ----------------
    task automatic drive(input int m, input bit rd, input bit wr,
                         input logic [3:0] a, input logic [31:0] d);
        if (m == 0) begin
            s0.read = rd; s0.write = wr; s0.address = a; s0.writedata = d;
        end else begin
            s1.read = rd; s1.write = wr; s1.address = a; s1.writedata = d;
        end
    endtask

    task automatic load_mem(input logic [3:0] a, input logic [31:0] d);
        tb_load = 1'b1; tb_load_addr = a; tb_load_data = d;
        @(posedge csi_clk); #1;
        tb_load = 1'b0;
        model_mem[a] = d;
    endtask

    // Expects to be called 1 ns after a rising edge; returns aligned the same way.
    task automatic xfer(input int m, input bit rd, input bit wr,
                        input logic [3:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdata, output bit other_ack);
        drive(m, rd, wr, a, d);
        lat = -1; rdata = '0; other_ack = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge csi_clk);
            if ((m == 0 ? s1.waitrequest : s0.waitrequest) == 1'b0) other_ack = 1'b1;
            if ((m == 0 ? s0.waitrequest : s1.waitrequest) == 1'b0) begin
                lat = c;
                rdata = (m == 0) ? s0.readdata : s1.readdata;
                break;
            end
        end
        @(posedge csi_clk); #1;
        drive(m, 1'b0, 1'b0, a, d);
    endtask

    task automatic apply_init_model();
        logic [127:0] pf;
        logic [127:0] fp;
        int addrs [8];
        pf = P_PINFUNC; fp = P_FUNCPIN;
        addrs = '{2, 3, 6, 7, 10, 11, 14, 15};
        for (int k = 0; k < 8; k++)
            model_mem[addrs[k]] = (k % 2 == 1) ? fp[32*(k/2) +: 32] : pf[32*(k/2) +: 32];
    endtask

    task automatic do_reset();
        rsi_reset_n = 1'b0;
        drive(0, 0, 0, 4'd0, 32'd0);
        drive(1, 0, 0, 4'd0, 32'd0);
        repeat (3) @(posedge csi_clk);
        #1 rsi_reset_n = 1'b1;
`ifdef PERIDOT_PFC_BOOTINIT_EN
        repeat (10) @(posedge csi_clk);
        #1;
        apply_init_model();
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge csi_clk);
        checks++; if (s0.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait0 got=%b exp=1", s0.waitrequest); end
        checks++; if (s1.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait1 got=%b exp=1", s1.waitrequest); end
        checks++; if (s0.readdata !== 32'd0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", s0.readdata); end
        checks++; if (s1.readdata !== 32'd0) begin errors++; $display("FAIL reset_rdata1 got=%h exp=0", s1.readdata); end
        checks++; if (coe_pfc_write !== 1'b0) begin errors++; $display("FAIL reset_pfc_write got=%b exp=0", coe_pfc_write); end
        checks++; if (coe_pfc_address !== 4'd0) begin errors++; $display("FAIL reset_pfc_addr got=%h exp=0", coe_pfc_address); end
        checks++; if (coe_pfc_writedata !== 32'd0) begin errors++; $display("FAIL reset_pfc_wdata got=%h exp=0", coe_pfc_writedata); end
        checks++; if (coe_pfc_reset !== 1'b1) begin errors++; $display("FAIL reset_pfc_reset got=%b exp=1", coe_pfc_reset); end
        checks++; if (coe_pfc_clk !== 1'b0) begin errors++; $display("FAIL pfc_clk_follow got=%b exp=0", coe_pfc_clk); end
    endtask

`ifdef PERIDOT_PFC_BOOTINIT_EN
    task automatic test_bootinit();
        logic [127:0] pf;
        logic [127:0] fp;
        int addrs [8];
        int lat;
        bit stalled_ok;
        pf = P_PINFUNC; fp = P_FUNCPIN;
        addrs = '{2, 3, 6, 7, 10, 11, 14, 15};
        rsi_reset_n = 1'b0;
        repeat (2) @(posedge csi_clk);
        #1 obs_q.delete();
        drive(0, 1'b0, 1'b1, 4'd1, 32'h0000_ABCD);
        rsi_reset_n = 1'b1;
        lat = -1; stalled_ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge csi_clk);
            if (s0.waitrequest == 1'b0) begin lat = c; break; end
        end
        if (obs_q.size() < 8) stalled_ok = 1'b0;
        @(posedge csi_clk); #1;
        drive(0, 1'b0, 1'b0, 4'd1, 32'h0000_ABCD);
        checks++; if (!stalled_ok || lat < 10) begin errors++; $display("FAIL boot_stall lat=%0d writes_before_ack=%0d exp_min_lat=10", lat, obs_q.size()); end
        checks++; if (obs_q.size() != 9) begin errors++; $display("FAIL boot_count got=%0d exp=9", obs_q.size()); end
        for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== {4'(addrs[k]), (k % 2 == 1) ? fp[32*(k/2) +: 32] : pf[32*(k/2) +: 32]}) begin
                errors++; $display("FAIL boot_write%0d got=%h", k, obs_q[k]);
            end
        end
        if (obs_q.size() == 9) begin
            checks++; if (obs_q[8] !== {4'd1, 32'h0000_ABCD}) begin errors++; $display("FAIL boot_master_write got=%h exp=%h", obs_q[8], {4'd1, 32'h0000_ABCD}); end
        end
        apply_init_model();
        model_mem[1] = 32'h0000_ABCD;
    endtask
`endif

    task automatic test_write();
        int lat; logic [31:0] rd; bit oth;
        obs_q.delete();
        xfer(0, 1'b0, 1'b1, 4'd1, 32'h0000_FF5A, lat, rd, oth);
        model_mem[1] = 32'h0000_FF5A;
        checks++; if (lat != 2) begin errors++; $display("FAIL write_latency got=%0d exp=2", lat); end
        checks++; if (oth) begin errors++; $display("FAIL write_other_ack got=1 exp=0"); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== {4'd1, 32'h0000_FF5A}) begin
            errors++; $display("FAIL write_pfc count=%0d first=%h exp=1 x %h", obs_q.size(), obs_q.size() ? obs_q[0] : 36'h0, {4'd1, 32'h0000_FF5A});
        end
        obs_q.delete();
        xfer(1, 1'b0, 1'b1, 4'd15, 32'hFFFF_FFFF, lat, rd, oth);
        model_mem[15] = 32'hFFFF_FFFF;
        checks++; if (lat != 2) begin errors++; $display("FAIL write_b2b_latency got=%0d exp=2", lat); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== {4'd15, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL write_addr15 count=%0d exp=1", obs_q.size());
        end
    endtask

    task automatic test_read();
        int lat; logic [31:0] rd; bit oth;
        load_mem(4'd0, 32'h0000_00C3);
        xfer(1, 1'b1, 1'b0, 4'd0, 32'd0, lat, rd, oth);
        checks++; if (lat != 2) begin errors++; $display("FAIL read_latency got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h0000_00C3) begin errors++; $display("FAIL read_data got=%h exp=000000c3", rd); end
        checks++; if (oth) begin errors++; $display("FAIL read_other_ack got=1 exp=0"); end
    endtask

    task automatic test_rw_both();
        int lat; logic [31:0] rd; bit oth;
        logic [31:0] d;
        d = $urandom;
        obs_q.delete();
        xfer(0, 1'b1, 1'b1, 4'd5, d, lat, rd, oth);
        model_mem[5] = d;
        checks++; if (obs_q.size() != 1 || obs_q[0] !== {4'd5, d}) begin
            errors++; $display("FAIL rw_both_write count=%0d exp=1 x %h", obs_q.size(), {4'd5, d});
        end
        xfer(1, 1'b1, 1'b0, 4'd5, 32'd0, lat, rd, oth);
        checks++; if (rd !== d) begin errors++; $display("FAIL rw_both_readback got=%h exp=%h", rd, d); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; bit oth;
        int m; bit is_wr; logic [3:0] a; logic [31:0] d;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(0, 1);
            is_wr = $urandom_range(0, 1);
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            xfer(m, !is_wr, is_wr, a, d, lat, rd, oth);
            checks++; if (lat != 2) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=2", i, lat); end
            if (is_wr) begin
                model_mem[a] = d;
                exp_q.push_back({a, d});
            end else begin
                checks++; if (rd !== model_mem[a]) begin errors++; $display("FAIL rand_read[%0d] addr=%0d got=%h exp=%h", i, a, rd, model_mem[a]); end
            end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_write[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_contention();
        logic [3:0] a0, a1;
        bit ack0, ack1;
        int exp_next, n0, n1, first_ack;
        do_reset();
        a0 = 4'($urandom_range(0, 15)); a1 = 4'($urandom_range(0, 15));
        drive(0, 1'b1, 1'b0, a0, 32'd0);
        drive(1, 1'b1, 1'b0, a1, 32'd0);
        exp_next = 0; n0 = 0; n1 = 0; first_ack = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge csi_clk);
            ack0 = (s0.waitrequest == 1'b0);
            ack1 = (s1.waitrequest == 1'b0);
            if ((ack0 || ack1) && first_ack < 0) first_ack = c;
            if (ack0 && ack1) begin checks++; errors++; $display("FAIL cont_double_ack cycle=%0d", c); end
            if (ack0 || ack1) begin
                checks++; if ((ack1 ? 1 : 0) != exp_next) begin errors++; $display("FAIL cont_order cycle=%0d got=%0d exp=%0d", c, ack1 ? 1 : 0, exp_next); end
                exp_next = 1 - exp_next;
            end
            if (ack0) begin
                n0++;
                checks++; if (s0.readdata !== model_mem[a0]) begin errors++; $display("FAIL cont_rdata0 got=%h exp=%h", s0.readdata, model_mem[a0]); end
            end
            if (ack1) begin
                n1++;
                checks++; if (s1.readdata !== model_mem[a1]) begin errors++; $display("FAIL cont_rdata1 got=%h exp=%h", s1.readdata, model_mem[a1]); end
            end
            @(posedge csi_clk); #1;
            if (ack0) begin a0 = 4'($urandom_range(0, 15)); drive(0, 1'b1, 1'b0, a0, 32'd0); end
            if (ack1) begin a1 = 4'($urandom_range(0, 15)); drive(1, 1'b1, 1'b0, a1, 32'd0); end
        end
        drive(0, 1'b0, 1'b0, a0, 32'd0);
        drive(1, 1'b0, 1'b0, a1, 32'd0);
        checks++; if (first_ack != 2) begin errors++; $display("FAIL cont_first_ack got=%0d exp=2", first_ack); end
        checks++; if (n0 != 5 || n1 != 5) begin errors++; $display("FAIL cont_fairness got=%0d/%0d exp=5/5", n0, n1); end
        @(posedge csi_clk); #1;
    endtask

    task automatic test_drop_request();
        int lat, lows; logic [31:0] d; int rlat; logic [31:0] rd; bit oth;
        d = $urandom;
        obs_q.delete();
        drive(0, 1'b0, 1'b1, 4'd9, d);
        @(negedge csi_clk);
        @(posedge csi_clk); #1;
        drive(0, 1'b0, 1'b0, 4'd9, d);
        lat = -1; lows = 0;
        for (int c = 1; c < 5; c++) begin
            @(negedge csi_clk);
            if (s0.waitrequest == 1'b0) begin lows++; if (lat < 0) lat = c; end
        end
        @(posedge csi_clk); #1;
        model_mem[9] = d;
        checks++; if (lat != 2 || lows != 1) begin errors++; $display("FAIL drop_ack lat=%0d lows=%0d exp=2/1", lat, lows); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== {4'd9, d}) begin errors++; $display("FAIL drop_write count=%0d exp=1", obs_q.size()); end
        xfer(1, 1'b1, 1'b0, 4'd9, 32'd0, rlat, rd, oth);
        checks++; if (rlat != 2 || rd !== d) begin errors++; $display("FAIL drop_followup lat=%0d data=%h exp=2/%h", rlat, rd, d); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; bit oth, early_ack;
        logic [31:0] d;
        load_mem(4'd12, 32'hDEAD_BEEF);
        drive(0, 1'b1, 1'b0, 4'd12, 32'd0);
        @(negedge csi_clk);
        @(posedge csi_clk); #2;
        rsi_reset_n = 1'b0;
        #1;
        checks++; if (s0.waitrequest !== 1'b1 || s1.waitrequest !== 1'b1) begin errors++; $display("FAIL midrst_wait got=%b%b exp=11", s0.waitrequest, s1.waitrequest); end
        checks++; if (s0.readdata !== 32'd0 || s1.readdata !== 32'd0) begin errors++; $display("FAIL midrst_rdata got=%h exp=0", s0.readdata); end
        checks++; if (coe_pfc_address !== 4'd0 || coe_pfc_write !== 1'b0 || coe_pfc_reset !== 1'b1) begin
            errors++; $display("FAIL midrst_pfc addr=%h wr=%b rst=%b exp=0/0/1", coe_pfc_address, coe_pfc_write, coe_pfc_reset);
        end
        early_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge csi_clk);
            if (s0.waitrequest == 1'b0) early_ack = 1'b1;
        end
        checks++; if (early_ack) begin errors++; $display("FAIL midrst_no_ack got=1 exp=0"); end
        drive(0, 1'b0, 1'b0, 4'd12, 32'd0);
        @(posedge csi_clk); #1;
        rsi_reset_n = 1'b1;
`ifdef PERIDOT_PFC_BOOTINIT_EN
        repeat (10) @(posedge csi_clk);
        #1;
        apply_init_model();
`endif
        d = $urandom;
        obs_q.delete();
        xfer(1, 1'b0, 1'b1, 4'd3, d, lat, rd, oth);
        model_mem[3] = d;
        checks++; if (lat != 2) begin errors++; $display("FAIL midrst_after_latency got=%0d exp=2", lat); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== {4'd3, d}) begin errors++; $display("FAIL midrst_after_write count=%0d exp=1", obs_q.size()); end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rsi_reset_n = 1'b0;
        drive(0, 0, 0, 4'd0, 32'd0);
        drive(1, 0, 0, 4'd0, 32'd0);
        @(posedge csi_clk); #1;
        for (int i = 0; i < 16; i++) load_mem(4'(i), $urandom);
        test_reset();
`ifdef PERIDOT_PFC_BOOTINIT_EN
        test_bootinit();
`endif
        do_reset();
        test_write();
        test_read();
        test_rw_both();
        test_random();
        test_drop_request();
        test_contention();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
